// File: rtl/fe_mux_core.sv
// fe_mux_core: frame-synchronous front-end mux with sync lock FSM, DDR frame clock and lane serialiser.
// Optional macro FE_MUX_DDR_SAMPLE_EN: capture data_in_180 as the second DDR half of each lane.
module fe_mux_core #(
    parameter int unsigned DIV_LOG2   = 1,
    parameter int unsigned N_DATA     = 2,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_MAX   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              sync_in,
    input  logic              cmd_in,
    input  logic [N_DATA-1:0] data_in_0,
    input  logic [N_DATA-1:0] data_in_180,
    output logic              clk_out_0,
    output logic              clk_out_180,
    output logic              cmd_out,
    output logic              cmd_out_inv,
    output logic              data_out_0,
    output logic              data_out_180,
    output logic              out_en,
    output logic [1:0]        lock_state,
    output logic [7:0]        sync_err_cnt
);

    localparam int unsigned PH_W  = DIV_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;

    localparam logic [PH_W-1:0]  LAST     = '1;
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W:0]    HALF_ONE = (PH_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] MISS_TGT = CNT_W'(MISS_MAX);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_SAT  = '1;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [PH_W-1:0]      phase, phase_nxt;
    logic [CNT_W-1:0]     good, good_nxt;
    logic [CNT_W-1:0]     miss, miss_nxt;
    logic [ERR_W-1:0]     err_cnt, err_nxt;
    logic                 err_inc;
    logic                 at_last;

    logic [N_DATA-1:0][1:0] shadow, shadow_nxt;
    logic                   cmd_shadow, cmd_shadow_nxt;
    logic [N_DATA-1:0]      lane_lo;
    logic [1:0]             lane_sel;
    logic [PH_W:0]          h0_p1, h1_p1;

    logic out_en_nxt;
    logic clk0_nxt, clk180_nxt;
    logic cmd_nxt, cmd_inv_nxt;
    logic d0_nxt, d180_nxt;

`ifdef FE_MUX_DDR_SAMPLE_EN
    assign lane_lo = data_in_180;
`else
    logic unused_data_in_180;
    assign unused_data_in_180 = ^data_in_180;
    assign lane_lo            = data_in_0;
`endif

    assign at_last      = (phase == LAST);
    assign lock_state   = state;
    assign sync_err_cnt = err_cnt;

    // Lock FSM state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_HUNT;
            phase   <= '0;
            good    <= '0;
            miss    <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            good    <= good_nxt;
            miss    <= miss_nxt;
            err_cnt <= err_nxt;
        end
    end

    // Lock FSM next state; a PLL drop overrides all sync handling
    always_comb begin
        state_nxt = state;
        phase_nxt = phase + PH_ONE;
        good_nxt  = good;
        miss_nxt  = miss;
        err_inc   = 1'b0;

        if (!pll_locked) begin
            state_nxt = ST_HUNT;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (sync_in) begin
                        phase_nxt = '0;
                        good_nxt  = '0;
                        state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (sync_in && at_last) begin
                        good_nxt = good + CNT_ONE;
                        if (good_nxt == LOCK_TGT) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (sync_in) begin
                        phase_nxt = '0;
                        good_nxt  = '0;
                    end else if (at_last) begin
                        state_nxt = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (at_last) begin
                        if (sync_in) begin
                            miss_nxt = '0;
                        end else begin
                            miss_nxt = miss + CNT_ONE;
                            if (miss_nxt == MISS_TGT) begin
                                state_nxt = ST_HUNT;
                                err_inc   = 1'b1;
                            end
                        end
                    end else if (sync_in) begin
                        phase_nxt = '0;
                        good_nxt  = '0;
                        state_nxt = ST_CHECK;
                        err_inc   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                end
            endcase
        end

        err_nxt = err_cnt;
        if (err_inc && (err_cnt != ERR_SAT)) begin
            err_nxt = err_cnt + ERR_ONE;
        end
    end

    // Frame capture at the last phase of each frame
    always_comb begin
        shadow_nxt     = shadow;
        cmd_shadow_nxt = cmd_shadow;
        if (at_last) begin
            for (int unsigned k = 0; k < N_DATA; k++) begin
                shadow_nxt[k] = {data_in_0[k], lane_lo[k]};
            end
            cmd_shadow_nxt = cmd_in;
        end
    end

    // Serialiser lane select; phases past the last lane idle at zero
    always_comb begin
        lane_sel = 2'b00;
        for (int unsigned k = 0; k < N_DATA; k++) begin
            if (32'(phase) == k) begin
                lane_sel = shadow[k];
            end
        end
    end

    // Output next values; the clock MSB of (h+1) mod 2F marks the high half
    always_comb begin
        h0_p1       = {phase, 1'b0} + HALF_ONE;
        h1_p1       = {phase, 1'b1} + HALF_ONE;
        clk0_nxt    = h0_p1[PH_W];
        clk180_nxt  = h1_p1[PH_W];
        out_en_nxt  = (state == ST_LOCKED) && pll_locked;
        d0_nxt      = out_en_nxt & lane_sel[1];
        d180_nxt    = out_en_nxt & lane_sel[0];
        cmd_nxt     = out_en_nxt & cmd_shadow;
        cmd_inv_nxt = out_en_nxt & ~cmd_shadow;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow       <= '0;
            cmd_shadow   <= 1'b0;
            clk_out_0    <= 1'b0;
            clk_out_180  <= 1'b0;
            cmd_out      <= 1'b0;
            cmd_out_inv  <= 1'b0;
            data_out_0   <= 1'b0;
            data_out_180 <= 1'b0;
            out_en       <= 1'b0;
        end else begin
            shadow       <= shadow_nxt;
            cmd_shadow   <= cmd_shadow_nxt;
            clk_out_0    <= clk0_nxt;
            clk_out_180  <= clk180_nxt;
            cmd_out      <= cmd_nxt;
            cmd_out_inv  <= cmd_inv_nxt;
            data_out_0   <= d0_nxt;
            data_out_180 <= d180_nxt;
            out_en       <= out_en_nxt;
        end
    end

endmodule

// File: tb/tb_fe_mux_core.sv
// tb_fe_mux_core: directed and randomized checks of fe_mux_core against a behavioural frame model.
module tb_fe_mux_core;

    localparam int DIV_LOG2   = 1;
    localparam int N_DATA     = 2;
    localparam int LOCK_COUNT = 4;
    localparam int MISS_MAX   = 2;
    localparam int F          = 2 ** DIV_LOG2;
    localparam int LAST       = F - 1;

    logic              clk;
    logic              rst;
    logic              pll_locked;
    logic              sync_in;
    logic              cmd_in;
    logic [N_DATA-1:0] data_in_0;
    logic [N_DATA-1:0] data_in_180;
    logic              clk_out_0, clk_out_180, cmd_out, cmd_out_inv;
    logic              data_out_0, data_out_180, out_en;
    logic [1:0]        lock_state;
    logic [7:0]        sync_err_cnt;

    fe_mux_core #(
        .DIV_LOG2   (DIV_LOG2),
        .N_DATA     (N_DATA),
        .LOCK_COUNT (LOCK_COUNT),
        .MISS_MAX   (MISS_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sync_in      (sync_in),
        .cmd_in       (cmd_in),
        .data_in_0    (data_in_0),
        .data_in_180  (data_in_180),
        .clk_out_0    (clk_out_0),
        .clk_out_180  (clk_out_180),
        .cmd_out      (cmd_out),
        .cmd_out_inv  (cmd_out_inv),
        .data_out_0   (data_out_0),
        .data_out_180 (data_out_180),
        .out_en       (out_en),
        .lock_state   (lock_state),
        .sync_err_cnt (sync_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame position, lock status (0 hunt, 1 check, 2 locked), counters
    int         m_phase, m_state, m_good, m_miss, m_err;
    logic [1:0] m_sh [N_DATA];
    logic       m_cmd_sh;
    logic       e_clk0, e_clk180, e_cmd, e_cmdi, e_d0, e_d180, e_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic fclk(input int h);
        return ((h + 1) % (2 * F)) >= F;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_state = 0; m_good = 0; m_miss = 0; m_err = 0;
        for (int k = 0; k < N_DATA; k++) m_sh[k] = 2'b00;
        m_cmd_sh = 1'b0;
        {e_clk0, e_clk180, e_cmd, e_cmdi, e_d0, e_d180, e_en} = '0;
    endtask

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    // One clock edge of the frame behaviour, evaluated with the inputs held over that edge
    task automatic model_step();
        int   ph;
        int   st;
        logic en;
        ph = m_phase;
        st = m_state;
        en = (st == 2) && pll_locked;
        e_en     = en;
        e_clk0   = fclk(2 * ph);
        e_clk180 = fclk(2 * ph + 1);
        if (en && ph < N_DATA) {e_d0, e_d180} = m_sh[ph];
        else                   {e_d0, e_d180} = 2'b00;
        e_cmd  = en & m_cmd_sh;
        e_cmdi = en & ~m_cmd_sh;
        if (ph == LAST) begin
            for (int k = 0; k < N_DATA; k++) begin
`ifdef FE_MUX_DDR_SAMPLE_EN
                m_sh[k] = {data_in_0[k], data_in_180[k]};
`else
                m_sh[k] = {data_in_0[k], data_in_0[k]};
`endif
            end
            m_cmd_sh = cmd_in;
        end
        m_phase = (ph + 1) % F;
        if (!pll_locked) begin
            m_state = 0;
        end else if (st == 0) begin
            if (sync_in) begin m_phase = 0; m_good = 0; m_state = 1; end
        end else if (st == 1) begin
            if (sync_in && ph == LAST) begin
                m_good++;
                if (m_good == LOCK_COUNT) begin m_state = 2; m_miss = 0; end
            end else if (sync_in) begin
                m_phase = 0; m_good = 0;
            end else if (ph == LAST) begin
                m_state = 0;
            end
        end else begin
            if (ph == LAST) begin
                if (sync_in) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == MISS_MAX) begin m_state = 0; bump_err(); end
                end
            end else if (sync_in) begin
                m_phase = 0; m_good = 0; m_state = 1; bump_err();
            end
        end
    endtask

    task automatic compare_all();
        check("clk_out_0",    clk_out_0,    e_clk0);
        check("clk_out_180",  clk_out_180,  e_clk180);
        check("out_en",       out_en,       e_en);
        check("lock_state",   lock_state,   m_state);
        check("sync_err_cnt", sync_err_cnt, m_err);
        check("data_out_0",   data_out_0,   e_d0);
        check("data_out_180", data_out_180, e_d180);
        check("cmd_out",      cmd_out,      e_cmd);
        check("cmd_out_inv",  cmd_out_inv,  e_cmdi);
    endtask

    // Drive at the falling edge, step the model on the rising edge, compare at the next falling edge
    task automatic cycle(input logic s, input logic p, input logic c,
                         input logic [N_DATA-1:0] a, input logic [N_DATA-1:0] b);
        sync_in = s; pll_locked = p; cmd_in = c; data_in_0 = a; data_in_180 = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rnd_cycle(input logic s, input logic p);
        cycle(s, p, 1'($urandom), N_DATA'($urandom), N_DATA'($urandom));
    endtask

    task automatic lock_up();
        for (int g = 0; g < 200 && m_state != 2; g++) rnd_cycle(m_phase == LAST, 1'b1);
        check("lock_up", lock_state, 2);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_lock", lock_state, 0);
        check("rst_err",  sync_err_cnt, 0);
        check("rst_en",   out_en, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int         n_sync;
        int         err_before;
        logic [1:0] exp_l0, exp_l1;
        rst = 1'b1; pll_locked = 1'b0; sync_in = 1'b0; cmd_in = 1'b0;
        data_in_0 = '0; data_in_180 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Acquire: one HUNT sync then LOCK_COUNT aligned syncs
        n_sync = 0;
        for (int g = 0; g < 100 && n_sync < LOCK_COUNT + 1; g++) begin
            if (m_phase == LAST) begin
                cycle(1'b1, 1'b1, 1'b0, '0, '0);
                n_sync++;
                if (n_sync == 1) check("acq_check", lock_state, 1);
            end else begin
                cycle(1'b0, 1'b1, 1'b0, '0, '0);
            end
        end
        check("acq_locked", lock_state, 2);
        check("acq_en_lag", out_en, 0);
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        check("acq_en", out_en, 1);

        // Data capture and serialisation of a known pattern
        while (m_phase != LAST) cycle(1'b0, 1'b1, 1'b0, '0, '0);
`ifdef FE_MUX_DDR_SAMPLE_EN
        cycle(1'b1, 1'b1, 1'b1, 2'b01, 2'b10);
        exp_l0 = 2'b10; exp_l1 = 2'b01;
`else
        cycle(1'b1, 1'b1, 1'b1, 2'b10, 2'b01);
        exp_l0 = 2'b00; exp_l1 = 2'b11;
`endif
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        check("lane0", {data_out_0, data_out_180}, exp_l0);
        check("cmd_hi", cmd_out, 1);
        check("cmd_inv_lo", cmd_out_inv, 0);
        cycle(1'b1, 1'b1, 1'b0, '0, '0);
        check("lane1", {data_out_0, data_out_180}, exp_l1);

        // Loss of sync: MISS_MAX missing frame syncs
        n_sync = 0;
        for (int g = 0; g < 100 && n_sync < MISS_MAX; g++) begin
            if (m_phase == LAST) n_sync++;
            rnd_cycle(1'b0, 1'b1);
        end
        check("miss_hunt", lock_state, 0);
        check("miss_err", sync_err_cnt, 1);
        rnd_cycle(1'b0, 1'b1);
        check("miss_en", out_en, 0);
        check("miss_data", {data_out_0, data_out_180}, 0);

        // Misaligned sync while locked
        lock_up();
        if (m_phase == LAST) rnd_cycle(1'b1, 1'b1);
        rnd_cycle(1'b1, 1'b1);
        check("misalign_check", lock_state, 1);
        check("misalign_err", sync_err_cnt, 2);

        // Asynchronous reset in the middle of a locked frame
        lock_up();
        rnd_cycle(m_phase == LAST, 1'b1);
        mid_reset();

        // Randomized traffic with occasional PLL drops, misses and resets
        for (int i = 0; i < 2000; i++) begin
            logic s;
            logic p;
            p = ($urandom_range(0, 199) != 0);
            if (m_phase == LAST) s = ($urandom_range(0, 99) < 88);
            else                 s = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 499) == 0) mid_reset();
            rnd_cycle(s, p);
        end

        // Saturation: 300 misaligned syncs from lock
        for (int i = 0; i < 300; i++) begin
            lock_up();
            if (m_phase == LAST) rnd_cycle(1'b1, 1'b1);
            rnd_cycle(1'b1, 1'b1);
        end
        check("sat_err", sync_err_cnt, 255);

        // PLL drop while locked
        lock_up();
        err_before = m_err;
        rnd_cycle(1'b0, 1'b0);
        check("pll_hunt", lock_state, 0);
        check("pll_err", sync_err_cnt, err_before);
        check("pll_en", out_en, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
